// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : Serial receiver (start, LSB-first data, optional even parity,
//               stop), with mid-bit sampling on a 2-flop synchronized line.
//               Optional parity bit enabled by the macro UART_RX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int transfer_speed = 4800,
    parameter int package_size   = 8,
    parameter int frequency      = 27_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rx,
    output logic [package_size-1:0] data,
    output logic                    data_valid,
    output logic                    frame_error,
    output logic                    parity_error
);

    localparam int              c_clks      = frequency / transfer_speed;
    localparam logic [26:0]     c_full_last = 27'(c_clks - 1);
    localparam logic [26:0]     c_half_last = 27'(c_clks / 2 - 1);
    localparam int              c_bw        = $clog2(package_size + 1);
    localparam logic [c_bw-1:0] c_bit_last  = c_bw'(package_size - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
    } state_t;
`endif

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_rx_meta;
    logic                    r_rx_s;
    logic [26:0]             r_cnt;
    logic [c_bw-1:0]         r_bit_cnt;
    logic [package_size-1:0] r_shift;
    logic                    r_armed;
    logic                    w_cnt_clr;
    logic                    w_shift_en;
    logic                    w_stop_hit;
    logic                    w_par_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

`ifdef UART_RX_PARITY_EN
    logic w_par_hit;
`endif

    always_comb begin
        w_state_next = r_state;
        w_cnt_clr    = 1'b0;
        w_shift_en   = 1'b0;
        w_stop_hit   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_hit    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s && r_armed) begin
                    w_state_next = S_START;
                    w_cnt_clr    = 1'b1;
                end
            end
            S_START: begin
                if (r_cnt == c_half_last) begin
                    if (!r_rx_s) begin
                        w_state_next = S_DATA;
                        w_cnt_clr    = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (r_cnt == c_full_last) begin
                    w_cnt_clr  = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == c_bit_last) begin
`ifdef UART_RX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (r_cnt == c_full_last) begin
                    w_cnt_clr    = 1'b1;
                    w_par_hit    = 1'b1;
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Back to IDLE on the sample cycle so a start edge half a bit later is seen.
                if (r_cnt == c_full_last) begin
                    w_cnt_clr    = 1'b1;
                    w_stop_hit   = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= 27'd0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            if (w_cnt_clr)             r_cnt <= 27'd0;
            else if (r_state != S_IDLE) r_cnt <= r_cnt + 27'd1;

            if (r_state == S_START)    r_bit_cnt <= '0;
            else if (w_shift_en)       r_bit_cnt <= r_bit_cnt + 1'b1;

            if (w_shift_en) r_shift <= {r_rx_s, r_shift[package_size-1:1]};
        end
    end

    // A stop bit seen low disarms start detection until the line returns high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     r_armed <= 1'b1;
        else if (w_stop_hit && !r_rx_s) r_armed <= 1'b0;
        else if (r_rx_s)                r_armed <= 1'b1;
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_par_err <= 1'b0;
        else if (w_par_hit) r_par_err <= r_rx_s ^ (^r_shift);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) parity_error <= 1'b0;
        else        parity_error <= w_stop_hit & r_par_err;
    end

    assign w_par_ok = ~r_par_err;
`else
    assign w_par_ok     = 1'b1;
    assign parity_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data        <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            data_valid  <= w_stop_hit & r_rx_s & w_par_ok;
            frame_error <= w_stop_hit & ~r_rx_s;
            if (w_stop_hit && r_rx_s && w_par_ok) data <= r_shift;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx at 16 clk/bit; expected pulses
//               are queued when a frame is driven and matched by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int c_bit = 16;
`ifdef UART_RX_PARITY_EN
    localparam int c_par_off = 16;
`else
    localparam int c_par_off = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_error;
    logic       parity_error;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [7:0] last_good = 8'h00;

    typedef struct {
        logic [7:0] data;
        logic [2:0] flags;   // {data_valid, frame_error, parity_error}
        int         cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       flip;
        int         gap;
    } vec_t;
    vec_t vecs[7];

    uart_rx #(
        .transfer_speed(100_000),
        .package_size  (8),
        .frequency     (1_600_000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .data        (data),
        .data_valid  (data_valid),
        .frame_error (frame_error),
        .parity_error(parity_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (data_valid || frame_error || parity_error)) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got dv/fe/pe=%b%b%b expected none (cycle %0d)",
                         data_valid, frame_error, parity_error, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pulse_flags", {29'd0, data_valid, frame_error, parity_error}, {29'd0, e.flags});
                chk("pulse_cycle", cyc, e.cyc);
                if (e.flags[2]) last_good = e.data;
                chk("pulse_data", {24'd0, data}, {24'd0, last_good});
            end
        end
    end

    // All driving tasks are entered and left just after a rising edge.
    task automatic idle(input int n);
        #1 rx = 1'b1;
        repeat (n) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip, input bit expect_it);
        exp_t e;
        #1 rx = 1'b0;
        if (expect_it) begin
            e.data  = d;
            e.flags = {stop & ~flip, ~stop, flip};
            e.cyc   = cyc + 155 + c_par_off;
            sb.push_back(e);
        end
        repeat (c_bit) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = d[i];
            repeat (c_bit) @(posedge clk);
        end
`ifdef UART_RX_PARITY_EN
        #1 rx = (^d) ^ flip;
        repeat (c_bit) @(posedge clk);
`endif
        #1 rx = stop;
        repeat (c_bit) @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h5A, 1'b1, 1'b0, 0};
        vecs[1] = '{8'hFF, 1'b1, 1'b0, 0};
        vecs[2] = '{8'h00, 1'b1, 1'b0, 0};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 20};
        vecs[4] = '{8'h81, 1'b1, 1'b0, 0};
        vecs[5] = '{8'h7E, 1'b1, 1'b0, 0};
        vecs[6] = '{8'hA5, 1'b1, 1'b0, 10};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", {24'd0, data}, 32'd0);
        chk("rst_dv", {31'd0, data_valid}, 32'd0);
        chk("rst_fe", {31'd0, frame_error}, 32'd0);
        chk("rst_pe", {31'd0, parity_error}, 32'd0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);

        // Table: back-to-back frames, gap only where one is listed
        for (int v = 0; v < 7; v++) begin
            send_frame(vecs[v].d, vecs[v].stop, vecs[v].flip, 1'b1);
            if (vecs[v].gap > 0) idle(vecs[v].gap);
        end
        idle(10);

        // Start glitch: 5 clk low must produce nothing and leave the FSM idle
        #1 rx = 1'b0;
        repeat (5) @(posedge clk);
        idle(40);
        send_frame(8'h69, 1'b1, 1'b0, 1'b1);
        idle(10);

        // Framing error followed by a line held low: no new frame until it rises
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        repeat (200) @(posedge clk);
        idle(30);
        send_frame(8'h42, 1'b1, 1'b0, 1'b1);
        idle(10);

        // Reset during data bit 4 of 0xA5, then 0x11
        #1 rx = 1'b0;
        repeat (c_bit) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            #1 rx = 8'hA5 >> i;
            repeat (c_bit) @(posedge clk);
        end
        #1 rx = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        last_good = 8'h00;
        chk("midrst_data", {24'd0, data}, 32'd0);
        chk("midrst_dv", {31'd0, data_valid}, 32'd0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        send_frame(8'h11, 1'b1, 1'b0, 1'b1);
        idle(10);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        idle(5);
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        idle(10);
`endif

        for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        idle(50);
        #1;
        chk("final_data", {24'd0, data}, {24'd0, last_good});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
